// File: rtl/priority_mux_pkg.sv
// Shared definitions for the priority multiplexer arbiter: mode encodings and
// index-width helper.
package priority_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width that never collapses to zero, even for tiny channel counts.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Wrap-around priority picker: first set request searching downward from start.
module prio_pick
  import priority_mux_pkg::*;
#(
  parameter int unsigned N = 6,
  localparam int unsigned CW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] start,
  output logic [N-1:0]  grant_onehot,
  output logic [CW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int j;
    j            = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(start) + int'(N) - k) % int'(N);
      if (!any && req[j]) begin
        any             = 1'b1;
        grant_idx       = CW'(j);
        grant_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_mux_arb.sv
// Registered N-channel priority / round-robin multiplexer with valid/ready on
// every input and on the single output.
module priority_mux_arb
  import priority_mux_pkg::*;
#(
  parameter int unsigned N = 6,
  parameter int unsigned W = 8,
  localparam int unsigned CW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [CW-1:0]   out_chan,
  input  logic            out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_chan_q, out_chan_d;
  logic [CW-1:0] last_grant_q, last_grant_d;

  logic [CW-1:0] start;
  logic [N-1:0]  grant_onehot;
  logic [CW-1:0] grant_idx;
  logic          any;
  logic          load;
  logic [W-1:0]  sel_data;

  always_comb begin
    start = CW'(N - 1);
    unique case (mode)
      MODE_FIXED: start = CW'(N - 1);
      MODE_RR:    start = (last_grant_q == '0) ? CW'(N - 1) : last_grant_q - 1'b1;
      default:    start = CW'(N - 1);
    endcase
  end

  prio_pick #(
    .N (N)
  ) u_pick (
    .req          (in_valid),
    .start        (start),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any)
  );

  // Reset gates load so in_ready stays low while the block is held in reset.
  assign load     = rst_n & (~out_valid_q | out_ready) & any;
  assign in_ready = load ? grant_onehot : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_onehot[i]) sel_data = sel_data | in_data[i*W +: W];
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = sel_data;
      out_chan_d   = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      last_grant_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
